rx_pkt_stager: RTL
==================

Name: rx_pkt_stager

Overview:
- Store-and-forward staging buffer between the receive MAC-side AXI-Stream and the AXI write-DMA engine.
- Accepts whole frames into an internal dword FIFO and counts their byte length.
- Once a frame is complete and a host buffer address is available, issues one address/byte-count command to the DMA, then replays the frame on its output stream.
- Reports a per-frame status word for descriptor write-back.

Parameters:
- ADDRESS_BITS, 32, width of buffer/command address.
- LENGTH_BITS, 16, width of byte counts.
- DEPTH_BITS, 9, data FIFO depth = 2^DEPTH_BITS dwords; this is also the maximum frame size in dwords.
- LEN_DEPTH_BITS, 2, length FIFO depth = 2^LEN_DEPTH_BITS frames.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_tdata  in  32  ingress frame data
- s_tkeep  in  4  ingress byte enables; must be contiguous from the first byte lane
- s_tlast  in  1  last beat of frame
- s_tvalid  in  1  ingress valid
- s_tready  out  1  ingress ready
- buf_address  in  ADDRESS_BITS  host buffer address for the next frame
- buf_valid  in  1  buffer address available
- buf_ready  out  1  one-cycle pulse; buffer address consumed
- cmd_address  out  ADDRESS_BITS  DMA command address
- cmd_bytes  out  LENGTH_BITS  DMA command byte count
- cmd_valid  out  1  DMA command valid
- cmd_ready  in  1  DMA command ready
- m_tdata  out  32  egress data
- m_tkeep  out  4  egress byte enables
- m_tlast  out  1  egress last beat
- m_tvalid  out  1  egress valid
- m_tready  in  1  egress ready
- sts_bytes  out  LENGTH_BITS  byte length of the completed frame
- sts_trunc  out  1  frame was truncated
- sts_valid  out  1  one-cycle status pulse

Behaviour:
- Reset values: s_tready=0, buf_ready=0, cmd_valid=0, m_tvalid=0, sts_valid=0, sts_trunc=0. cmd_address, cmd_bytes, sts_bytes are 0. FIFOs are empty. Egress FSM is in S_IDLE. Reset asserted mid-frame discards all stored and partial frames.
- Ingress:
  - s_tready = data FIFO not full AND length FIFO not full, OR the discard state is active.
  - Each accepted beat writes {data, keep, last} to the data FIFO.
  - The byte accumulator adds popcount(s_tkeep).
  - The dword counter increments per written beat.
- Truncation:
  - When the dword counter reaches 2^DEPTH_BITS on a beat without s_tlast, that beat is written with last forced to 1 and the length is pushed with trunc=1.
  - Ingress then enters discard: beats are accepted (s_tready=1) but not written, until an s_tlast beat is accepted inclusive.
- On a written last beat: push {bytes, trunc} to the length FIFO, then clear both counters. Counter width is LENGTH_BITS; the byte count cannot wrap because the maximum is 4·2^DEPTH_BITS < 2^LENGTH_BITS.
- Egress FSM:
  - S_IDLE: when the length FIFO is non-empty —
    - bytes==0 → S_DROP.
    - Otherwise, when buf_valid=1: latch cmd_address=buf_address and cmd_bytes=bytes, set cmd_valid=1 → S_CMD.
  - S_CMD: hold cmd_valid and values stable until cmd_valid&&cmd_ready. Then pulse buf_ready for 1 cycle, drop cmd_valid → S_DATA.
  - S_DATA: m_tvalid = data FIFO not empty. m_* come from the FIFO head. Pop on m_tvalid&&m_tready. On a popped beat with m_tlast → S_STS.
  - S_DROP (zero-byte frame, single keep=0 last beat): pop FIFO beats internally through the last beat without asserting m_tvalid or cmd_valid. buf_ready is not pulsed and the buffer is not consumed → S_STS.
  - S_STS: sts_valid=1 for exactly one cycle with sts_bytes/sts_trunc from the length FIFO head. Pop the length FIFO → S_IDLE.
- Latency: the data FIFO uses registered-read RAM. The first egress beat may present no earlier than 1 cycle after S_DATA entry. S_IDLE evaluation of a frame occurs no earlier than 1 cycle after its last-beat write.
- Simultaneous push/pop on either FIFO in the same cycle is legal; full/empty flags reflect the net occupancy. Ingress of later frames continues while egress of an earlier frame is in progress.
- Exactly one frame is in flight on the egress side. A frame is never replayed before its command handshake completes.

Test Plan:
- 60-byte frame (15 beats, keep=F), buf_address=0x1000_0002 → cmd_address=0x1000_0002, cmd_bytes=60, 15 egress beats with last on beat 15, one buf_ready pulse, sts_bytes=60, sts_trunc=0.
- 61-byte frame with last keep=1 → cmd_bytes=61, last m_tkeep=1, sts_bytes=61.
- Single beat keep=0 last → no cmd_valid, no m_tvalid, no buf_ready, sts_valid with sts_bytes=0.
- DEPTH_BITS=4, 20-beat frame keep=F → 16 beats stored (beat 16 last), beats 17–20 accepted and discarded, cmd_bytes=64, sts_trunc=1; the next frame is unaffected.
- Four back-to-back 8-byte frames with buf_valid=0 → s_tready drops when the length FIFO is full (4 frames). Raising buf_valid drains 4 commands in order, with cmd_valid held stable while cmd_ready=0 for 5 cycles.
- Assert aresetn low mid-egress → all outputs return to reset values; after release, a new 8-byte frame completes normally.

Source files
------------

// File: rtl/rx_pkt_stager.sv
// rx_pkt_stager: store-and-forward staging buffer between the receive MAC
// AXI-Stream and the write-DMA engine.
//
// Whole frames are collected in a dword FIFO while their byte length is
// counted. Once a frame is complete and a host buffer address is offered, one
// {address, byte count} command is issued, then the frame is replayed on the
// egress stream. A status word is pulsed per frame for descriptor write-back.
//
// Ports:
//   aclk, aresetn                    clock, asynchronous active-low reset
//   s_tdata/tkeep/tlast/tvalid/tready ingress AXI-Stream (tkeep contiguous)
//   buf_address/buf_valid/buf_ready   host buffer offer; buf_ready pulses on use
//   cmd_address/cmd_bytes/cmd_valid/cmd_ready  DMA command
//   m_tdata/tkeep/tlast/tvalid/tready egress AXI-Stream
//   sts_bytes/sts_trunc/sts_valid     per-frame status pulse
module rx_pkt_stager #(
  parameter int unsigned ADDRESS_BITS   = 32,
  parameter int unsigned LENGTH_BITS    = 16,
  parameter int unsigned DEPTH_BITS     = 9,
  parameter int unsigned LEN_DEPTH_BITS = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             s_tdata,
  input  logic [3:0]              s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [ADDRESS_BITS-1:0] buf_address,
  input  logic                    buf_valid,
  output logic                    buf_ready,
  output logic [ADDRESS_BITS-1:0] cmd_address,
  output logic [LENGTH_BITS-1:0]  cmd_bytes,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [31:0]             m_tdata,
  output logic [3:0]              m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [LENGTH_BITS-1:0]  sts_bytes,
  output logic                    sts_trunc,
  output logic                    sts_valid
);

  localparam int unsigned Depth    = 2 ** DEPTH_BITS;
  localparam int unsigned LenDepth = 2 ** LEN_DEPTH_BITS;
  localparam int unsigned DataW    = 32 + 4 + 1;

  localparam logic [DEPTH_BITS:0]     DataFull  = (DEPTH_BITS + 1)'(Depth);
  localparam logic [LEN_DEPTH_BITS:0] LenFull   = (LEN_DEPTH_BITS + 1)'(LenDepth);
  localparam logic [LENGTH_BITS-1:0]  LastDword = LENGTH_BITS'(Depth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StDrop,
    StSts
  } state_e;

  // ---------------------------------------------------------------------------
  // Data FIFO (registered-read RAM)
  // ---------------------------------------------------------------------------
  logic [DataW-1:0]      mem [Depth];
  logic [DataW-1:0]      rd_data_q;
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
  logic [DEPTH_BITS:0]   dcount_q, dcount_d;
  logic                  stale_q;
  logic                  wr_en, pop, fifo_valid, dfifo_full;
  logic                  wr_last;

  // ---------------------------------------------------------------------------
  // Length FIFO ({bytes, trunc} per frame)
  // ---------------------------------------------------------------------------
  logic [LENGTH_BITS:0]      len_mem [LenDepth];
  logic [LEN_DEPTH_BITS-1:0] lwr_ptr_q, lrd_ptr_q;
  logic [LEN_DEPTH_BITS:0]   lcount_q, lcount_d;
  logic                      len_push, len_pop, lfifo_full, lfifo_empty;
  logic [LENGTH_BITS-1:0]    head_bytes;
  logic                      head_trunc;

  // ---------------------------------------------------------------------------
  // Ingress
  // ---------------------------------------------------------------------------
  logic                   ready_en_q;
  logic                   discard_q;
  logic [LENGTH_BITS-1:0] byte_cnt_q, dword_cnt_q;
  logic [LENGTH_BITS-1:0] keep_bytes, frame_bytes;
  logic                   accept, trunc_beat;

  assign dfifo_full  = (dcount_q == DataFull);
  assign lfifo_full  = (lcount_q == LenFull);
  assign lfifo_empty = (lcount_q == '0);

  // ready_en_q keeps s_tready low while reset is asserted.
  assign s_tready   = ready_en_q & ((~dfifo_full & ~lfifo_full) | discard_q);
  assign accept     = s_tvalid & s_tready;
  assign wr_en      = accept & ~discard_q;
  assign trunc_beat = wr_en & (dword_cnt_q == LastDword) & ~s_tlast;
  assign wr_last    = s_tlast | trunc_beat;
  assign len_push   = wr_en & wr_last;

  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < 4; i++) begin
      keep_bytes = keep_bytes + LENGTH_BITS'(s_tkeep[i]);
    end
  end

  assign frame_bytes = byte_cnt_q + keep_bytes;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q  <= 1'b0;
      discard_q   <= 1'b0;
      byte_cnt_q  <= '0;
      dword_cnt_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (wr_en) begin
        if (wr_last) begin
          byte_cnt_q  <= '0;
          dword_cnt_q <= '0;
        end else begin
          byte_cnt_q  <= frame_bytes;
          dword_cnt_q <= dword_cnt_q + 1'b1;
        end
      end
      if (trunc_beat) begin
        discard_q <= 1'b1;
      end else if (discard_q && accept && s_tlast) begin
        discard_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data FIFO implementation
  // ---------------------------------------------------------------------------
  // Look ahead to the next entry on a pop so the registered read keeps up with
  // back-to-back pops.
  assign rd_addr = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {s_tdata, s_tkeep, wr_last};
    end
    rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    dcount_d = dcount_q;
    unique case ({wr_en, pop})
      2'b10:   dcount_d = dcount_q + 1'b1;
      2'b01:   dcount_d = dcount_q - 1'b1;
      default: dcount_d = dcount_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dcount_q <= '0;
      stale_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      dcount_q <= dcount_d;
      // The read port sampled the old contents if the same entry was written
      // this cycle; the head is then re-read on the following cycle.
      stale_q  <= wr_en & (wr_ptr_q == rd_addr);
    end
  end

  assign fifo_valid = (dcount_q != '0) & ~stale_q;

  // ---------------------------------------------------------------------------
  // Length FIFO implementation
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (len_push) begin
      len_mem[lwr_ptr_q] <= {frame_bytes, trunc_beat};
    end
  end

  always_comb begin
    lcount_d = lcount_q;
    unique case ({len_push, len_pop})
      2'b10:   lcount_d = lcount_q + 1'b1;
      2'b01:   lcount_d = lcount_q - 1'b1;
      default: lcount_d = lcount_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lwr_ptr_q <= '0;
      lrd_ptr_q <= '0;
      lcount_q  <= '0;
    end else begin
      if (len_push) lwr_ptr_q <= lwr_ptr_q + 1'b1;
      if (len_pop)  lrd_ptr_q <= lrd_ptr_q + 1'b1;
      lcount_q <= lcount_d;
    end
  end

  assign head_bytes = len_mem[lrd_ptr_q][LENGTH_BITS:1];
  assign head_trunc = len_mem[lrd_ptr_q][0];

  // ---------------------------------------------------------------------------
  // Egress FSM
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [ADDRESS_BITS-1:0] cmd_address_q, cmd_address_d;
  logic [LENGTH_BITS-1:0]  cmd_bytes_q, cmd_bytes_d;
  logic                    buf_ready_q, buf_ready_d;
  logic                    data_arm_q;
  logic                    sts_valid_q, sts_trunc_q;
  logic [LENGTH_BITS-1:0]  sts_bytes_q;
  logic                    head_last;
  logic                    m_tvalid_c;

  assign head_last = rd_data_q[0];

  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_address_d = cmd_address_q;
    cmd_bytes_d   = cmd_bytes_q;
    buf_ready_d   = 1'b0;
    pop           = 1'b0;
    len_pop       = 1'b0;
    m_tvalid_c    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!lfifo_empty) begin
          if (head_bytes == '0) begin
            state_d = StDrop;
          end else if (buf_valid) begin
            cmd_valid_d   = 1'b1;
            cmd_address_d = buf_address;
            cmd_bytes_d   = head_bytes;
            state_d       = StCmd;
          end
        end
      end
      StCmd: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          buf_ready_d = 1'b1;
          state_d     = StData;
        end
      end
      StData: begin
        // data_arm_q holds the first egress beat back one cycle after entry.
        m_tvalid_c = data_arm_q & fifo_valid;
        if (m_tvalid_c && m_tready) begin
          pop = 1'b1;
          if (head_last) state_d = StSts;
        end
      end
      StDrop: begin
        if (fifo_valid) begin
          pop = 1'b1;
          if (head_last) state_d = StSts;
        end
      end
      StSts: begin
        len_pop = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      cmd_valid_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_bytes_q   <= '0;
      buf_ready_q   <= 1'b0;
      data_arm_q    <= 1'b0;
      sts_valid_q   <= 1'b0;
      sts_bytes_q   <= '0;
      sts_trunc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_address_q <= cmd_address_d;
      cmd_bytes_q   <= cmd_bytes_d;
      buf_ready_q   <= buf_ready_d;
      data_arm_q    <= (state_q == StData);
      sts_valid_q   <= (state_q == StSts);
      if (state_q == StSts) begin
        sts_bytes_q <= head_bytes;
        sts_trunc_q <= head_trunc;
      end
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_address = cmd_address_q;
  assign cmd_bytes   = cmd_bytes_q;
  assign buf_ready   = buf_ready_q;
  assign m_tvalid    = m_tvalid_c;
  assign m_tdata     = rd_data_q[36:5];
  assign m_tkeep     = rd_data_q[4:1];
  assign m_tlast     = rd_data_q[0];
  assign sts_valid   = sts_valid_q;
  assign sts_bytes   = sts_bytes_q;
  assign sts_trunc   = sts_trunc_q;

endmodule
